// File: rtl/fp_mul_pkg.sv
// Shared types and derived constants for the pipelined floating-point multiplier.
// Latency: none (package only). Backpressure: none (package only).
// Constants are functions of the exponent/mantissa widths so every instance derives its own.
package fp_mul_pkg;

    // Signed exponent width carried down the pipe; holds sums for EXP_LEN up to 13.
    localparam int PL_EXP_W = 16;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_cls_e;

    typedef struct packed {
        logic                       valid;
        logic                       sign;
        fp_cls_e                    cls_a;
        fp_cls_e                    cls_b;
        logic signed [PL_EXP_W-1:0] exp;
    } stage_t;

    function automatic int fp_bias(input int exp_len);
        return (1 << (exp_len - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_len);
        return (1 << exp_len) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_len, input int man_len);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < exp_len; i++) q[man_len + i] = 1'b1;
        q[man_len - 1] = 1'b1;
        return q;
    endfunction

    // Subnormals (exp == 0) classify as zero and are flushed.
    function automatic fp_cls_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_nz);
        if (exp_zero) return FP_ZERO;
        if (exp_ones) return frac_nz ? FP_NAN : FP_INF;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_mul_round_pack.sv
// Final-stage normalise, round, range check and special-value mux for fp_mul_pipe.
// Latency: combinational. Backpressure: none; the caller registers the result.
// FP_MUL_ROUND_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_round_pack
    import fp_mul_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                              sign_i,
    input  fp_cls_e                           cls_a_i,
    input  fp_cls_e                           cls_b_i,
    input  logic signed [PL_EXP_W-1:0]        exp_i,
    input  logic [2*(MANTISSA_LEN+1)-1:0]     prod_i,
    output logic [EXP_LEN+MANTISSA_LEN:0]     result_o,
    output logic                              ovf_o,
    output logic                              unf_o,
    output logic                              inv_o
);
    localparam int M  = MANTISSA_LEN;
    localparam int MW = M + 1;
    localparam int PW = 2 * MW;
    localparam int W  = EXP_LEN + M + 1;
    localparam logic signed [PL_EXP_W-1:0] EXP_MAX_S = PL_EXP_W'(fp_exp_max(EXP_LEN));
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_LEN, M));

    logic                       msb;
    logic [PW-1:0]              norm;
    logic                       rup;
    logic [MW:0]                mant;
    logic                       carry;
    logic [M-1:0]               frac;
    logic signed [PL_EXP_W-1:0] exp_n;
`ifndef FP_MUL_ROUND_EN
    logic                       unused_lsbs;
`endif

    always_comb begin
        msb  = prod_i[PW-1];
        norm = msb ? prod_i : (prod_i << 1);
`ifdef FP_MUL_ROUND_EN
        // Leading one at norm[PW-1]: lsb is norm[M+1], guard norm[M], round norm[M-1].
        rup = norm[M] & (norm[M-1] | (|norm[M-2:0]) | norm[M+1]);
`else
        rup         = 1'b0;
        unused_lsbs = ^norm[M:0];
`endif
        mant  = {1'b0, norm[PW-1:M+1]} + {{MW{1'b0}}, rup};
        carry = mant[MW];
        frac  = carry ? mant[M:1] : mant[M-1:0];
        exp_n = exp_i;
        if (msb)   exp_n = exp_n + PL_EXP_W'(1);
        if (carry) exp_n = exp_n + PL_EXP_W'(1);

        result_o = '0;
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        inv_o    = 1'b0;
        if (cls_a_i == FP_NAN || cls_b_i == FP_NAN ||
            (cls_a_i == FP_INF && cls_b_i == FP_ZERO) ||
            (cls_a_i == FP_ZERO && cls_b_i == FP_INF)) begin
            result_o = QNAN;
            inv_o    = 1'b1;
        end else if (cls_a_i == FP_INF || cls_b_i == FP_INF) begin
            result_o = {sign_i, {EXP_LEN{1'b1}}, {M{1'b0}}};
        end else if (cls_a_i == FP_ZERO || cls_b_i == FP_ZERO) begin
            result_o = {sign_i, {(W-1){1'b0}}};
        end else if (!exp_n[PL_EXP_W-1] && exp_n >= EXP_MAX_S) begin
            result_o = {sign_i, {EXP_LEN{1'b1}}, {M{1'b0}}};
            ovf_o    = 1'b1;
        end else if (exp_n[PL_EXP_W-1] || exp_n == '0) begin
            result_o = {sign_i, {(W-1){1'b0}}};
            unf_o    = 1'b1;
        end else begin
            result_o = {sign_i, exp_n[EXP_LEN-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined floating-point multiplier with zero/inf/NaN handling and flags.
// Latency: 4 cycles from input transfer; one result per cycle when unstalled.
// Backpressure: whole pipe stalls while the output is held (in_ready = out_ready | ~out_valid); FP_MUL_ROUND_EN selects RNE.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0] a,
    input  logic [EXP_LEN+MANTISSA_LEN:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0] product,
    output logic                          flag_overflow,
    output logic                          flag_underflow,
    output logic                          flag_invalid
);
    localparam int W   = EXP_LEN + MANTISSA_LEN + 1;
    localparam int M   = MANTISSA_LEN;
    localparam int MW  = M + 1;
    localparam int LO  = MW / 2;
    localparam int HI  = MW - LO;
    localparam int PW  = 2 * MW;
    localparam int HHW = 2 * HI;
    localparam int HLW = HI + LO;
    localparam int LLW = 2 * LO;
    localparam int BIAS = fp_bias(EXP_LEN);

    logic           en;
    stage_t         s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic [W-2:0]   opa_q, opb_q;
    logic [MW-1:0]  sig_a, sig_b;
    logic [HHW-1:0] pp_hh_d, pp_hh_q;
    logic [HLW-1:0] pp_hl_d, pp_hl_q, pp_lh_d, pp_lh_q;
    logic [LLW-1:0] pp_ll_d, pp_ll_q;
    logic [PW-1:0]  prod_d, prod_q;
    logic [W-1:0]   res;
    logic           ovf, unf, inv;
    logic           out_valid_q, ovf_q, unf_q, inv_q;
    logic [W-1:0]   product_q;

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sign  = a[W-1] ^ b[W-1];
        s1_d.cls_a = fp_classify(a[W-2:M] == '0, &a[W-2:M], |a[M-1:0]);
        s1_d.cls_b = fp_classify(b[W-2:M] == '0, &b[W-2:M], |b[M-1:0]);
    end

    // Split significands so each partial product is roughly a quarter-width multiply.
    always_comb begin
        sig_a    = {1'b1, opa_q[M-1:0]};
        sig_b    = {1'b1, opb_q[M-1:0]};
        pp_hh_d  = HHW'(sig_a[MW-1:LO]) * HHW'(sig_b[MW-1:LO]);
        pp_hl_d  = HLW'(sig_a[MW-1:LO]) * HLW'(sig_b[LO-1:0]);
        pp_lh_d  = HLW'(sig_a[LO-1:0])  * HLW'(sig_b[MW-1:LO]);
        pp_ll_d  = LLW'(sig_a[LO-1:0])  * LLW'(sig_b[LO-1:0]);
        s2_d     = s1_q;
        s2_d.exp = PL_EXP_W'(opa_q[W-2:M]) + PL_EXP_W'(opb_q[W-2:M]);
    end

    always_comb begin
        prod_d   = (PW'(pp_hh_q) << LLW) + (PW'(pp_hl_q) << LO) +
                   (PW'(pp_lh_q) << LO) + PW'(pp_ll_q);
        s3_d     = s2_q;
        s3_d.exp = s2_q.exp - PL_EXP_W'(BIAS);
    end

    fp_mul_round_pack #(
        .EXP_LEN      (EXP_LEN),
        .MANTISSA_LEN (MANTISSA_LEN)
    ) u_round_pack (
        .sign_i   (s3_q.sign),
        .cls_a_i  (s3_q.cls_a),
        .cls_b_i  (s3_q.cls_b),
        .exp_i    (s3_q.exp),
        .prod_i   (prod_q),
        .result_o (res),
        .ovf_o    (ovf),
        .unf_o    (unf),
        .inv_o    (inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            pp_hh_q     <= '0;
            pp_hl_q     <= '0;
            pp_lh_q     <= '0;
            pp_ll_q     <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else if (en) begin
            s1_q        <= s1_d;
            opa_q       <= a[W-2:0];
            opb_q       <= b[W-2:0];
            s2_q        <= s2_d;
            pp_hh_q     <= pp_hh_d;
            pp_hl_q     <= pp_hl_d;
            pp_lh_q     <= pp_lh_d;
            pp_ll_q     <= pp_ll_d;
            s3_q        <= s3_d;
            prod_q      <= prod_d;
            out_valid_q <= s3_q.valid;
            product_q   <= res;
            ovf_q       <= ovf;
            unf_q       <= unf;
            inv_q       <= inv;
        end
    end

    assign out_valid      = out_valid_q;
    assign product        = product_q;
    assign flag_overflow  = ovf_q;
    assign flag_underflow = unf_q;
    assign flag_invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (FP32): directed vectors, backpressure, random traffic, mid-stream reset.
// Expected results come from an exact integer-product reference model and a scoreboard queue.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;
    logic        fo, fu, fi;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          stall_lo = -1;
    int          stall_hi = -2;
    bit          rand_bp = 1'b0;
    logic [34:0] exp_q[$];

`ifdef FP_MUL_ROUND_EN
    localparam logic [31:0] RND_RES = 32'h40100002;
`else
    localparam logic [31:0] RND_RES = 32'h40100001;
`endif

    // Directed vectors: {ovf, unf, inv, product}
    logic [31:0] da [13] = '{32'hC0000000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
                             32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7FC00001,
                             32'h7F800000, 32'h00400000, 32'h00000000, 32'h3F800000,
                             32'h3FC00000};
    logic [31:0] db [13] = '{32'h3F000000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
                             32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'hFF800000, 32'h40000000, 32'hFF800000, 32'h3F800000,
                             32'h40000000};
    logic [34:0] de [13];

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .flag_overflow(fo), .flag_underflow(fu), .flag_invalid(fi)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e;
        longint unsigned p, q, scale;
        bit zx, zy, ix, iy, nx, ny;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return {3'b001, 32'h7FC00000};
        if (ix || iy) return {3'b000, s, 8'hFF, 23'h0};
        if (zx || zy) return {3'b000, s, 31'h0};
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        e = ex + ey - 127;
        scale = 64'd1 << 23;
        if (p >= (64'd1 << 47)) begin
            scale = 64'd1 << 24;
            e++;
        end
        q = p / scale;
`ifdef FP_MUL_ROUND_EN
        begin
            longint unsigned rem;
            rem = p % scale;
            if (2 * rem > scale || (2 * rem == scale && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q / 2;
                e++;
            end
        end
`endif
        if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b010, s, 31'h0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: r[30:23] = 8'h00;
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: r[30:23] = 8'hFF;
            3: r[30:23] = 8'($urandom_range(1, 20));
            4: r[30:23] = 8'($urandom_range(235, 254));
            default: r[30:23] = 8'($urandom_range(64, 190));
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [34:0] e);
        int n;
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic latency_test(input logic [31:0] x, input logic [31:0] y, input logic [34:0] e);
        int n;
        send(x, y, e);
        n = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(4));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        else         out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end

    // Monitor: samples mid-cycle, after out_ready has settled for the coming edge.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            check("in_ready", 64'(in_ready), 64'(out_ready | !out_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", product);
                end else if (out_ready) begin
                    check("result", 64'({fo, fu, fi, product}), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                    n_out++;
                end else begin
                    check("held_result", 64'({fo, fu, fi, product}), 64'(exp_q[0]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0;
        logic [31:0] x, y;
        de = '{{3'b000, 32'hBF800000}, {3'b000, RND_RES}, {3'b100, 32'h7F800000},
               {3'b010, 32'h00000000}, {3'b001, 32'h7FC00000}, {3'b000, 32'hFF800000},
               {3'b000, 32'h80000000}, {3'b001, 32'h7FC00000}, {3'b000, 32'hFF800000},
               {3'b000, 32'h00000000}, {3'b001, 32'h7FC00000}, {3'b000, 32'h3F800000},
               {3'b000, 32'h40400000}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_flags", 64'({fo, fu, fi}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        latency_test(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
        drain();

        for (int i = 0; i < 13; i++) send(da[i], db[i], de[i]);
        drain();

        // Backpressure: out_ready low for cycles 5..9 of an 8-deep burst.
        n0 = n_out;
        c0 = cyc;
        stall_lo = c0 + 5;
        stall_hi = c0 + 9;
        for (int i = 0; i < 8; i++) begin
            x = rand_op();
            y = rand_op();
            send(x, y, model(x, y));
        end
        drain();
        check("bp_delivered", 64'(n_out - n0), 64'(8));
        stall_lo = -1;
        stall_hi = -2;

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = rand_op();
            y = rand_op();
            send(x, y, model(x, y));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        rand_bp = 1'b0;
        drain();

        // Reset with the output register plus three stages occupied.
        for (int i = 0; i < 4; i++) begin
            x = rand_op();
            y = rand_op();
            send(x, y, model(x, y));
        end
        #3;
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_product", 64'(product), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("no_stale", 64'(out_valid), 64'(0));
        end
        latency_test(32'hC0000000, 32'h3F000000, {3'b000, 32'hBF800000});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed-latency float multiplier.
- Adds a valid/ready handshake with backpressure, round-to-nearest-even, special-value handling (zero, inf, NaN) and exception flags.
- Sits between operand-producing datapaths and downstream accumulators in the arithmetic cluster. One result per cycle when unstalled.

Parameters:
- EXP_LEN, 8, exponent field width (>=3).
- MANTISSA_LEN, 23, stored fraction width (>=2); the significand is MANTISSA_LEN+1 bits including the hidden 1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a and b are valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  EXP_LEN+MANTISSA_LEN+1  operand A {sign, exp, frac}.
- b  in  EXP_LEN+MANTISSA_LEN+1  operand B.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer accepts product.
- product  out  EXP_LEN+MANTISSA_LEN+1  result.
- flag_overflow  out  1  result overflowed to inf; qualified by out_valid.
- flag_underflow  out  1  nonzero result flushed to zero; qualified by out_valid.
- flag_invalid  out  1  NaN produced from inf*0 or a NaN input; qualified by out_valid.

Behaviour:
- Reset is asynchronous on rst_n low. All stage valid bits, out_valid, product and flags are cleared to 0. Datapath registers are also cleared.
- Reset mid-operation discards all in-flight operations. in_ready is 1 in the first cycle after reset deassertion.
- Pipeline enable: en = out_ready | ~v4, where v4 = out_valid. in_ready = en. A transfer occurs on in_valid & in_ready.
- When en=0, every stage holds its contents, and product and flags hold stable.
- Latency is 4 cycles from input transfer to out_valid with en held at 1. Throughput is 1 per cycle.
- S1: register the operands. Classify each operand:
  - zero: exp==0; subnormals are flushed to zero.
  - inf: exp all ones, frac==0.
  - nan: exp all ones, frac!=0.
  - Sign = sa^sb.
- S2: significands {1,frac} are split into high and low halves at (MANTISSA_LEN+1)/2. Four partial products are registered. Exponent sum ea+eb is taken as a zero-extended (EXP_LEN+2)-bit signed value.
- S3: partial products are summed into the 2*(MANTISSA_LEN+1)-bit product. Exponent becomes ea+eb-BIAS, where BIAS = 2^(EXP_LEN-1)-1.
- S4, normalise: if the product MSB is 1, shift right by 1 and add 1 to the exponent.
- S4, round: round to nearest, ties to even, using guard, round and sticky bits. A mantissa carry-out on rounding renormalises and adds 1 to the exponent.
- S4, range check:
  - exp >= 2^EXP_LEN-1: result is ±inf and flag_overflow=1.
  - exp <= 0: result is ±0 and flag_underflow=1.
- S4, special-case priority, highest first:
  1. Any NaN input, or inf*zero: canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), flag_invalid=1.
  2. inf * finite: ±inf, no flags.
  3. zero * finite: ±0 with the product sign, no flags.
  4. Otherwise the normal path.
- Flags are registered alongside product and apply only while out_valid=1. At most one flag is set per result.
- Simultaneous transfers: with out_valid & out_ready & in_valid & in_ready in the same cycle, the pipeline advances without a bubble.

Optional Feature:
- Macro FP_MUL_ROUND_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation (round toward zero). Guard, round and sticky logic is removed. Overflow, underflow and invalid behaviour is otherwise identical.
- Latency is 4 cycles in both builds.

Decomposition:
- Package fp_mul_pkg holds:
  - function-based constants BIAS, EXP_MAX and QNAN pattern, derived from the parameters;
  - an operand-class typedef enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - a stage-payload struct {valid, sign, cls_a, cls_b, exp}.
- Sub-module fp_mul_round_pack holds the S4 normalise, round, range check and special-case mux. It is combinational; the registers stay in the top.

Test Plan (FP32 defaults, out_ready=1 unless stated):
- 0x3FC00000 * 0x40000000 (1.5 * 2.0) -> 0x40400000 exactly 4 cycles after transfer, no flags. Also -2.0*0.5: 0xC0000000 * 0x3F000000 -> 0xBF800000.
- Rounding: 0x3FC00001 * 0x3FC00001 -> 0x40100002 with FP_MUL_ROUND_EN defined; 0x40100001 with it undefined.
- Overflow and underflow:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000 with flag_overflow=1.
  - 0x00800000 * 0x00800000 -> 0x00000000 with flag_underflow=1.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000 with flag_invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, no flags.
  - 0x80000000 * 0x3F800000 -> 0x80000000, no flags.
- Backpressure: stream 8 back-to-back operand pairs while holding out_ready=0 from cycle 5 to 9. Required:
  - in_ready=0 while out_valid=1 and out_ready=0;
  - product held stable;
  - all 8 results delivered in order with none dropped or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight. Required: out_valid=0 immediately (async), no stale result after release, and the first post-reset operation returns correctly after 4 cycles.
